// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions: opcode constants, sequencer state encoding and operand-use helper.
// The optional perf counters are enabled with the HAZ_PERF_CNT_EN macro (see hazard_ctrl_unit).
package pipe_pkg;

  localparam logic [3:0] OP_LB   = 4'b1011;
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_JMP  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Loads, jumps and halts carry no register in the rt field.
  function automatic logic uses_rt(input logic [3:0] opcode);
    return !(opcode == OP_LB || opcode == OP_JMP || opcode == OP_HALT);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID/EX snapshot in, pipeline enables out; master is the pipeline side, slave is the hazard unit.
// Every signal is level-valued each cycle: there is no valid/ready handshake on this bus.
interface hazard_ctrl_unit_if;
  import pipe_pkg::*;

  logic [3:0] id_opcode;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic [3:0] ex_opcode;
  logic [2:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_br_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       halted;
  state_t     dbg_state;

  modport master (
    output id_opcode, id_rs, id_rt, ex_opcode, ex_rd, ex_reg_write, ex_br_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, halted, dbg_state
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, ex_opcode, ex_rd, ex_reg_write, ex_br_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, halted, dbg_state
  );

endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones once reached.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall / branch flush / halt sequencer driving PC, IF/ID and ID/EX enables.
// Define HAZ_PERF_CNT_EN to add saturating stall_cnt/flush_cnt perf counters.
module hazard_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input logic clk,
    input logic rst,
    hazard_ctrl_unit_if.slave hif
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Cycles still to hold after the entry cycle and the final LU_STALL cycle.
    localparam logic [2:0] CNT_INIT = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       lu_hit;

    assign lu_hit = (hif.ex_opcode == OP_LB) && hif.ex_reg_write &&
                    ((hif.ex_rd == hif.id_rs) || (uses_rt(hif.id_opcode) && (hif.ex_rd == hif.id_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        hif.pc_write    = 1'b1;
        hif.ifid_write  = 1'b1;
        hif.ifid_flush  = 1'b0;
        hif.idex_bubble = 1'b0;
        hif.halted      = 1'b0;
        if (rst) begin
            state_nxt       = RUN;
            cnt_nxt         = 3'd0;
            hif.pc_write    = 1'b0;
            hif.ifid_write  = 1'b0;
            hif.ifid_flush  = 1'b1;
            hif.idex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hif.ex_br_taken) begin
                        hif.ifid_flush  = 1'b1;
                        hif.idex_bubble = 1'b1;
                    end else if (hif.id_opcode == OP_JMP) begin
                        hif.ifid_flush = 1'b1;
                    end else if (lu_hit) begin
                        hif.pc_write    = 1'b0;
                        hif.ifid_write  = 1'b0;
                        hif.idex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nxt = LU_STALL;
                            cnt_nxt   = CNT_INIT;
                        end
                    end else if (hif.id_opcode == OP_HALT) begin
                        hif.pc_write   = 1'b0;
                        hif.ifid_write = 1'b0;
                        state_nxt      = HALT;
                    end
                end
                LU_STALL: begin
                    // A taken branch here means EX was not a bubble; follow the branch anyway.
                    if (hif.ex_br_taken) begin
                        hif.ifid_flush  = 1'b1;
                        hif.idex_bubble = 1'b1;
                        state_nxt       = RUN;
                        cnt_nxt         = 3'd0;
                    end else begin
                        hif.pc_write    = 1'b0;
                        hif.ifid_write  = 1'b0;
                        hif.idex_bubble = 1'b1;
                        if (cnt == 3'd0) begin
                            state_nxt = RUN;
                        end else begin
                            cnt_nxt = cnt - 3'd1;
                        end
                    end
                end
                HALT: begin
                    hif.pc_write    = 1'b0;
                    hif.ifid_write  = 1'b0;
                    hif.idex_bubble = 1'b1;
                    hif.halted      = 1'b1;
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    assign hif.dbg_state = state;

`ifdef HAZ_PERF_CNT_EN
    logic stall_inc, flush_inc;

    // Load-use stalls are the only non-reset, non-halt cycles that freeze PC while bubbling ID/EX.
    assign stall_inc = !rst && !hif.pc_write && hif.idex_bubble && !hif.halted;
    assign flush_inc = !rst && hif.ifid_flush;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (1- and 3-cycle load-use stall) share stimulus;
// a reference model pushes expected enables into a queue that a negedge monitor drains.
module tb_hazard_ctrl_unit;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if hif1 ();
  hazard_ctrl_unit_if hif3 ();

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .hif (hif1)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt1),
    .flush_cnt (flush_cnt1)
`endif
  );

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .hif (hif3)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt3),
    .flush_cnt (flush_cnt3)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Per cycle: {dut3, dut1}, each {pc_write, ifid_write, ifid_flush, idex_bubble, halted}.
  logic [9:0] exp_q[$];

  // Reference model: remaining stall cycles and parked flag per instance.
  int stall_left[2];
  bit parked[2];
  int stall_len[2] = '{1, 3};

`ifdef HAZ_PERF_CNT_EN
  logic [63:0] perf_q[$];
  int m_stall[2] = '{0, 0};
  int m_flush[2] = '{0, 0};
`endif

  function automatic logic [4:0] model_cycle(input int d, input logic r, input logic [3:0] iop,
                                             input logic [2:0] rs, input logic [2:0] rt,
                                             input logic [3:0] eop, input logic [2:0] rd,
                                             input logic rw, input logic br);
    logic [4:0] o;
    logic hit;
    bit reads_rt;
    reads_rt = (iop != OP_LB) && (iop != OP_JMP) && (iop != OP_HALT);
    hit = (eop == OP_LB) && rw && ((rd == rs) || (reads_rt && rd == rt));
    if (r) begin
      o = 5'b00110;
      stall_left[d] = 0;
      parked[d] = 0;
    end else if (parked[d]) begin
      o = 5'b00011;
    end else if (stall_left[d] > 0) begin
      if (br) begin
        o = 5'b11110;
        stall_left[d] = 0;
      end else begin
        o = 5'b00010;
        stall_left[d] = stall_left[d] - 1;
      end
    end else if (br) begin
      o = 5'b11110;
    end else if (iop == OP_JMP) begin
      o = 5'b11100;
    end else if (hit) begin
      o = 5'b00010;
      stall_left[d] = stall_len[d] - 1;
    end else if (iop == OP_HALT) begin
      o = 5'b00000;
      parked[d] = 1;
    end else begin
      o = 5'b11000;
    end
`ifdef HAZ_PERF_CNT_EN
    if (!r) begin
      if (o == 5'b00010 && m_stall[d] < 65535) m_stall[d] = m_stall[d] + 1;
      if (o[2] && m_flush[d] < 65535) m_flush[d] = m_flush[d] + 1;
    end
`endif
    return o;
  endfunction

  task automatic drive(input logic r, input logic [3:0] iop, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [3:0] eop, input logic [2:0] rd,
                       input logic rw, input logic br);
    logic [4:0] e1, e3;
    @(posedge clk);
    #1;
    rst = r;
    hif1.id_opcode = iop;  hif3.id_opcode = iop;
    hif1.id_rs = rs;       hif3.id_rs = rs;
    hif1.id_rt = rt;       hif3.id_rt = rt;
    hif1.ex_opcode = eop;  hif3.ex_opcode = eop;
    hif1.ex_rd = rd;       hif3.ex_rd = rd;
    hif1.ex_reg_write = rw; hif3.ex_reg_write = rw;
    hif1.ex_br_taken = br; hif3.ex_br_taken = br;
`ifdef HAZ_PERF_CNT_EN
    // Counters are registered: this cycle shows the totals of previous cycles.
    perf_q.push_back({16'(m_stall[1]), 16'(m_flush[1]), 16'(m_stall[0]), 16'(m_flush[0])});
    if (r) begin
      m_stall = '{0, 0};
      m_flush = '{0, 0};
    end
`endif
    e1 = model_cycle(0, r, iop, rs, rt, eop, rd, rw, br);
    e3 = model_cycle(1, r, iop, rs, rt, eop, rd, rw, br);
    exp_q.push_back({e3, e1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the enables are presented; compare against the oldest expectation.
  always @(negedge clk) begin
    logic [9:0] e, got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {hif3.pc_write, hif3.ifid_write, hif3.ifid_flush, hif3.idex_bubble, hif3.halted,
             hif1.pc_write, hif1.ifid_write, hif1.ifid_flush, hif1.idex_bubble, hif1.halted};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL enables t=%0t got=%b required=%b (dut3|dut1: pc,ifw,flush,bubble,halted)",
                 $time, got, e);
      end
    end
`ifdef HAZ_PERF_CNT_EN
    if (perf_q.size() > 0) begin
      logic [63:0] pe, pg;
      pe = perf_q.pop_front();
      pg = {stall_cnt3, flush_cnt3, stall_cnt1, flush_cnt1};
      checks++;
      if (pg !== pe) begin
        errors++;
        $display("FAIL perf_cnt t=%0t got=%h required=%h", $time, pg, pe);
      end
    end
`endif
  end

  initial begin
    logic r, br, rw;
    logic [3:0] iop, eop;
    rst = 1'b1;
    stall_left = '{0, 0};
    parked = '{0, 0};
    drive(1'b1, 4'h0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0);
    idle(2);
    // Load-use on rs
    drive(1'b0, 4'h0, 3'd3, 3'd0, OP_LB, 3'd3, 1'b1, 1'b0);
    idle(4);
    // rt dependency: SB-like op reads rt, LB does not
    drive(1'b0, 4'h9, 3'd0, 3'd2, OP_LB, 3'd2, 1'b1, 1'b0);
    idle(4);
    drive(1'b0, OP_LB, 3'd0, 3'd2, OP_LB, 3'd2, 1'b1, 1'b0);
    idle(2);
    // Load without reg_write never stalls
    drive(1'b0, 4'h0, 3'd5, 3'd5, OP_LB, 3'd5, 1'b0, 1'b0);
    // Taken branch masks a simultaneous load-use
    drive(1'b0, 4'h0, 3'd3, 3'd0, OP_LB, 3'd3, 1'b1, 1'b1);
    idle(2);
    // Jump flush, and a jump whose rs matches the load
    drive(1'b0, OP_JMP, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0);
    drive(1'b0, OP_JMP, 3'd4, 3'd4, OP_LB, 3'd4, 1'b1, 1'b0);
    idle(2);
    // Branch arriving mid-stall on the 3-cycle instance
    drive(1'b0, 4'h0, 3'd1, 3'd0, OP_LB, 3'd1, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b1);
    idle(2);
    // Halt parks for 20 cycles, then a 1-cycle reset
    drive(1'b0, OP_HALT, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0);
    drive(1'b0, OP_JMP, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b1);
    idle(19);
    drive(1'b1, 4'h0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0);
    idle(2);
    // Reset in the second cycle of a 3-cycle stall
    drive(1'b0, 4'h0, 3'd6, 3'd0, OP_LB, 3'd6, 1'b1, 1'b0);
    drive(1'b1, 4'h0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0) || ((parked[0] || parked[1]) && $urandom_range(0, 9) == 0);
      br = ($urandom_range(0, 11) == 0);
      iop = 4'($urandom_range(0, 15));
      if (iop == OP_HALT && $urandom_range(0, 5) != 0) iop = 4'h0;
      eop = ($urandom_range(0, 1) == 1) ? OP_LB : 4'($urandom_range(0, 15));
      rw = ($urandom_range(0, 3) != 0);
      drive(r, iop, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), eop,
            3'($urandom_range(0, 3)), rw, br);
    end
    idle(1);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
